// File: rtl/axi2ahb_pkg.sv
// Shared encodings and constants for the AXI-to-AHB bridge command path.
package axi2ahb_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WBURST = 2'd1,
    ST_RBURST = 2'd2
  } seq_state_t;

  localparam logic GRANT_WRITE = 1'b1;
  localparam logic GRANT_READ  = 1'b0;

  // cmd_id is {last_beat, id}: the last-beat flag sits just above the ID field.
  function automatic int unsigned cmd_last_bit(input int unsigned id_w);
    return id_w;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED / INCR / WRAP AXI bursts.
module axi_burst_addr_gen
  import axi2ahb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        len,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] inc;
  logic [ADDR_W-1:0] sum;
  logic [ADDR_W-1:0] mask;

  // Reserved burst encoding behaves like INCR.
  always_comb begin
    inc       = ADDR_W'(1) << size;
    sum       = addr + inc;
    mask      = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    next_addr = sum;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~mask) | (sum & mask);
      default:     next_addr = sum;
    endcase
  end

endmodule

// File: rtl/axi_cmd_sequencer.sv
// Round-robin AW/AR arbiter that expands bursts into per-beat command FIFO pushes.
module axi_cmd_sequencer
  import axi2ahb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 8
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [ID_W-1:0]   awid,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  input  logic [ID_W-1:0]   arid,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              arvalid,
  output logic              arready,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic              cmd_write,
  output logic [ID_W:0]     cmd_id,
  output logic [2:0]        cmd_size,
  output logic              cmd_push,
  input  logic              cmd_full,
  output logic [DATA_W-1:0] cmd_data,
  output logic              data_push,
  input  logic              data_full,
  output logic              wlast_err
);

  localparam int unsigned LAST_BIT = cmd_last_bit(ID_W);

  seq_state_t        state;
  seq_state_t        state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_nxt;
  logic [7:0]        len_q;
  logic [7:0]        cnt_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic [ID_W-1:0]   id_q;
  logic              last_grant;
  logic              fire;
  logic              last_beat;

  assign last_beat = (cnt_q == len_q);

  axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .addr      (addr_q),
    .len       (len_q),
    .size      (size_q),
    .burst     (burst_q),
    .next_addr (addr_nxt)
  );

  // FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next state plus handshake/push strobes; forced low while reset is held.
  always_comb begin
    state_nxt = state;
    awready   = 1'b0;
    arready   = 1'b0;
    wready    = 1'b0;
    cmd_push  = 1'b0;
    data_push = 1'b0;
    wlast_err = 1'b0;
    cmd_data  = '0;
    fire      = 1'b0;
    if (aresetn) begin
      unique case (state)
        ST_IDLE: begin
          awready = awvalid && (!arvalid || last_grant == GRANT_READ);
          arready = arvalid && !awready;
          if (awready)      state_nxt = ST_WBURST;
          else if (arready) state_nxt = ST_RBURST;
        end
        ST_WBURST: begin
          fire      = wvalid && !cmd_full && !data_full;
          wready    = fire;
          cmd_push  = fire;
          data_push = fire;
          if (fire) begin
            cmd_data  = wdata;
            wlast_err = (wlast != last_beat);
            if (last_beat) state_nxt = ST_IDLE;
          end
        end
        ST_RBURST: begin
          fire     = !cmd_full;
          cmd_push = fire;
          if (fire && last_beat) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Burst context: latched on a handshake, advanced on every fired beat.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      id_q       <= '0;
      last_grant <= GRANT_READ;
    end else if (awready) begin
      addr_q     <= awaddr;
      len_q      <= awlen;
      cnt_q      <= '0;
      size_q     <= awsize;
      burst_q    <= awburst;
      id_q       <= awid;
      last_grant <= GRANT_WRITE;
    end else if (arready) begin
      addr_q     <= araddr;
      len_q      <= arlen;
      cnt_q      <= '0;
      size_q     <= arsize;
      burst_q    <= arburst;
      id_q       <= arid;
      last_grant <= GRANT_READ;
    end else if (fire) begin
      cnt_q  <= cnt_q + 8'd1;
      addr_q <= addr_nxt;
    end
  end

  // Command fields straight from registers; last-beat flag only meaningful inside a burst.
  always_comb begin
    cmd_addr           = addr_q;
    cmd_size           = size_q;
    cmd_write          = (state == ST_WBURST);
    cmd_id             = '0;
    cmd_id[ID_W-1:0]   = id_q;
    cmd_id[LAST_BIT]   = (state != ST_IDLE) && last_beat;
  end

endmodule

// File: doc/axi_cmd_sequencer.md
# axi_cmd_sequencer

Sequences AXI write and read bursts onto the bridge's shared AXI-to-AHB command FIFOs (address, write/read state, ID, size, write data) in the `aclk` domain. It arbitrates round-robin between the AW and AR channels and expands each accepted burst into one FIFO entry per beat with the computed beat address. For writes it pairs each beat with one W beat. It sits between the AXI slave ports and the asynchronous FIFO wrapper, replacing ad-hoc channel muxing.

## Interface
Reset is asynchronous, active-low (`aresetn`); single clock `aclk`.

Parameters:
- `ADDR_W`, 32: address width.
- `DATA_W`, 64: data width.
- `ID_W`, 8: AXI ID width.

Ports:
- `aclk` in 1: clock.
- `aresetn` in 1: async active-low reset.
- `awid`/`awaddr`/`awlen`/`awsize`/`awburst` in ID_W/ADDR_W/8/3/2: write address.
- `awvalid` in 1 / `awready` out 1: AW handshake.
- `wdata` in DATA_W, `wlast` in 1: write data.
- `wvalid` in 1 / `wready` out 1: W handshake.
- `arid`/`araddr`/`arlen`/`arsize`/`arburst` in ID_W/ADDR_W/8/3/2: read address.
- `arvalid` in 1 / `arready` out 1: AR handshake.
- `cmd_addr` out ADDR_W: beat address.
- `cmd_write` out 1: 1 = write, 0 = read.
- `cmd_id` out ID_W+1: {last_beat, id}.
- `cmd_size` out 3: latched size.
- `cmd_push` out 1: write enable to the addr/state/id/size FIFOs.
- `cmd_full` in 1: OR of those FIFOs' full flags.
- `cmd_data` out DATA_W: write data to the data FIFO.
- `data_push` out 1: data FIFO write enable.
- `data_full` in 1: data FIFO full.
- `wlast_err` out 1: one-cycle pulse on a wlast mismatch.

## Operation
- FSM states: IDLE, WBURST, RBURST. Reset state is IDLE.
- IDLE arbitration:
  - `awready = awvalid && (!arvalid || last_grant==READ)`.
  - `arready = arvalid && !awready`.
  - `last_grant` resets to READ, so write wins the first tie.
- On an AW handshake: latch addr, len, size, burst, id. Set beat counter `cnt=0`, `last_grant=WRITE`, go to WBURST.
- On an AR handshake: the same latching, with `last_grant=READ`, go to RBURST.
- WBURST beat fires when `wvalid && !cmd_full && !data_full`. On a fire:
  - `wready=1`, `cmd_push=1`, `data_push=1`.
  - `cmd_data=wdata`, `cmd_write=1`.
- RBURST beat fires when `!cmd_full`. On a fire: `cmd_push=1`, `cmd_write=0`, `data_push=0`.
- `cmd_id[ID_W] = (cnt==len)`. `cmd_id[ID_W-1:0]` = latched id.
- After a fire: `cnt+1` and the address advances. On the beat where `cnt==len`, return to IDLE.
- Address update, with `inc = 1<<size`:
  - FIXED (00): unchanged.
  - INCR (01) and reserved (11): `addr+inc`.
  - WRAP (10): `mask=((len+1)<<size)-1`, then `addr=(addr&~mask)|((addr+inc)&mask)`.
- Legal `size` is 0..3. `cmd_size` carries the latched size unchanged.
- wlast: beat count comes from `awlen`; `wlast` does not end the burst. `wlast_err` pulses on a fired W beat when `wlast != (cnt==len)`.
- `wready`, `awready` and `arready` are never asserted outside the conditions above.

## Timing
- Reset values: all `*ready`, `cmd_push`, `data_push`, `wlast_err` = 0. `cmd_*` fields = 0. FSM = IDLE, `cnt=0`.
- Push/ready outputs are combinational from FSM registers and the full/valid inputs. Address/ID/size outputs come straight from registers.
- Latency: AW/AR handshake in cycle N, first push in N+1. One beat per cycle at full throughput.
- After the last beat: one IDLE cycle before the next handshake. A burst of L+1 beats occupies L+2 cycles.
- Full asserted: beat stalls with no push and no `wready`. State, `cnt` and addr hold; retry every cycle.
- Reset asserted mid-burst: immediate return to IDLE and all outputs to reset values. The partial burst is discarded.
- `awlen=255` makes `cnt` reach 255. `cnt` is 8-bit with no wrap issue, because exit happens at `cnt==len`.

## Structure
- Shared package `axi2ahb_pkg`:
  - burst encodings FIXED/INCR/WRAP;
  - FSM state enum;
  - `GRANT_WRITE`/`GRANT_READ` constants;
  - cmd_id bit layout constant (last-beat bit position).
- One natural sub-module: `axi_burst_addr_gen`, a combinational next-address unit (addr, len, size, burst → next addr), reusable by the read-response side.

## Test plan
- **INCR write:** AW addr=0x1000, len=3, size=3, burst=INCR, id=0x5A, with 4 W beats. Expect pushes at 0x1000/0x1008/0x1010/0x1018, cmd_write=1, cmd_id=0x05A ×3 then 0x15A. `cmd_data` equals each wdata in order.
- **WRAP read:** AR addr=0x2018, len=3, size=3, burst=WRAP. Expect addrs 0x2018, 0x2000, 0x2008, 0x2010, cmd_write=0, no data_push.
- **Arbitration:** `awvalid` and `arvalid` both high from reset. Expect write granted first, then read; with both held, grants alternate W, R, W.
- **Backpressure:** hold `cmd_full=1` for 3 cycles mid-burst at beat 2. Expect no push and `wready=0`, addr held; resume at the same address, total beats unchanged.
- **wlast mismatch:** len=1 write with `wlast=1` on beat 0. Expect `wlast_err` pulse on beat 0 and on beat 1; 2 beats pushed, FSM back in IDLE.
- **Reset mid-burst:** assert `aresetn=0` during beat 1 of len=7 INCR. Expect all outputs 0 immediately; after release, a new AR is accepted on the first cycle `arvalid` is seen.
